// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, fetch/decode register handshake and branch redirect.
interface fetch_unit_if #(
   parameter int unsigned PC_WIDTH    = 4,
   parameter int unsigned INSTR_WIDTH = 32
);
   logic [PC_WIDTH-1:0]    PC_out;
   logic [INSTR_WIDTH-1:0] IR_in;
   logic                   IR_valid;
   logic [INSTR_WIDTH-1:0] IR_data;
   logic [PC_WIDTH-1:0]    IR_pc;
   logic                   IR_ready;
   logic                   branch_taken;
   logic [PC_WIDTH-1:0]    branch_target;
   logic                   halt;

   modport master (
      output PC_out, IR_valid, IR_data, IR_pc, halt,
      input  IR_in, IR_ready, branch_taken, branch_target
   );

   modport slave (
      input  PC_out, IR_valid, IR_data, IR_pc, halt,
      output IR_in, IR_ready, branch_taken, branch_target
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures memory words into the fetch/decode register.
// Build option FETCH_WRAP_EN: PC wraps and fetch never halts (default: halt after LAST_PC).
module fetch_unit #(
   parameter int unsigned PC_WIDTH    = 4,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned LAST_PC     = 15
) (
   input  logic          clk,
   input  logic          reset,
   fetch_unit_if.master  fetch_if
);

   localparam logic [PC_WIDTH-1:0] RESET_PC_C = PC_WIDTH'(RESET_PC);
   localparam logic [PC_WIDTH-1:0] PC_ONE_C   = PC_WIDTH'(1);

   typedef enum logic [1:0] {S_START, S_RUN, S_HALT} state_e;

   state_e                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic                   valid_q, valid_d;
   logic [INSTR_WIDTH-1:0] data_q, data_d;
   logic [PC_WIDTH-1:0]    irpc_q, irpc_d;
`ifndef FETCH_WRAP_EN
   localparam logic [PC_WIDTH-1:0] LAST_PC_C = PC_WIDTH'(LAST_PC);
   logic                   halt_q, halt_d;
`endif

   // Next-state: redirect beats everything except reset; a fetch happens whenever the register is free.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      data_d  = data_q;
      irpc_d  = irpc_q;
`ifndef FETCH_WRAP_EN
      halt_d  = halt_q;
`endif
      if (fetch_if.branch_taken) begin
         state_d = S_RUN;
         pc_d    = fetch_if.branch_target;
         valid_d = 1'b0;
`ifndef FETCH_WRAP_EN
         halt_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            S_START: state_d = S_RUN;
            S_RUN: begin
               if (!valid_q || fetch_if.IR_ready) begin
                  data_d  = fetch_if.IR_in;
                  irpc_d  = pc_q;
                  valid_d = 1'b1;
                  pc_d    = pc_q + PC_ONE_C;
`ifndef FETCH_WRAP_EN
                  if (pc_q == LAST_PC_C) begin
                     pc_d    = pc_q;
                     state_d = S_HALT;
                     halt_d  = 1'b1;
                  end
`endif
               end
            end
            S_HALT: begin
               if (fetch_if.IR_ready) valid_d = 1'b0;
            end
            default: state_d = S_START;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_START;
         pc_q    <= RESET_PC_C;
         valid_q <= 1'b0;
         data_q  <= '0;
         irpc_q  <= '0;
`ifndef FETCH_WRAP_EN
         halt_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         irpc_q  <= irpc_d;
`ifndef FETCH_WRAP_EN
         halt_q  <= halt_d;
`endif
      end
   end

   assign fetch_if.PC_out   = pc_q;
   assign fetch_if.IR_valid = valid_q;
   assign fetch_if.IR_data  = data_q;
   assign fetch_if.IR_pc    = irpc_q;
`ifdef FETCH_WRAP_EN
   assign fetch_if.halt     = 1'b0;
`else
   assign fetch_if.halt     = halt_q;
`endif

endmodule
